prio_serialiser: RTL and testbench
==================================

# prio_serialiser

Parametrised, registered priority encoder that accepts an N-bit request vector and drains it one index per cycle over a valid/ready output stream. It extends the team's 8-to-3 combinational encoder in four ways: any width N, correct encoding when several bits are set, selectable fixed or round-robin priority, and backpressure. It sits between request-collection logic (interrupt lines, channel flags) and any consumer that services one index at a time.

## Interface
- N, default 8: request vector width, legal range 2..64, need not be a power of two.
- MODE, default 0: 0 = fixed priority, highest index first; 1 = round-robin.
- W (localparam) = $clog2(N): index width.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- req  input  N  request vector.
- in_valid  input  1  req is presented.
- in_ready  output  1  block can load a new vector.
- out_idx  output  W  index being granted.
- out_valid  output  1  out_idx is valid.
- out_ready  input  1  consumer accepts out_idx.
- out_last  output  1  out_idx is the last set bit of the current vector.

## Operation
- State:
  - pending[N-1:0], the bits not yet emitted.
  - ptr[W-1:0], the round-robin search start (used only when MODE=1).
- Two states, implied by pending:
  - IDLE: pending==0.
  - DRAIN: pending!=0.
- in_ready = (pending==0), combinational from the register.
- Load: when in_valid && in_ready, pending <= req at the clock edge. A req of 0 is accepted and dropped: no output, and in_ready stays 1.
- out_valid = (pending!=0).
- out_idx = selected bit of pending. When out_valid=0, out_idx = 0.
- Selection rules:
  - MODE=0: highest set index in pending.
  - MODE=1: first set bit found by searching downward from ptr, wrapping from 0 to N-1. The search includes ptr itself.
- Out handshake (out_valid && out_ready): clear pending[out_idx]. When MODE=1, also set ptr <= out_idx-1 modulo N, so granting index 0 sets ptr to N-1.
- out_last = out_valid && (pending has exactly one bit set).
- Load and handshake never coincide: a load requires pending==0, and a handshake requires pending!=0.
- No bypass: a vector loaded at edge t cannot be emitted at edge t.
- req bits with index ≥ N do not exist. Width arithmetic on ptr must handle non-power-of-two N: when N-1 is not all ones, the wrap from 0 goes to N-1, not to 2^W-1.

## Timing
- Reset (asynchronous, immediate on rst_n low, including mid-drain):
  - pending=0 and ptr=N-1.
  - in_ready=1, out_valid=0, out_idx=0, out_last=0.
  - A partially drained vector is discarded.
- Latency: vector accepted at edge t gives out_valid=1 with the first index in the cycle after t.
- Throughput: one index per cycle while out_ready=1. A vector with k set bits drains in k cycles.
- in_ready rises in the cycle after the handshake that carried out_last. Steady-state spacing is k+1 cycles per vector.
- Backpressure: while out_ready=0, pending, out_idx, out_valid and out_last are held stable.
- All outputs are combinational from registers only. No input reaches an output combinationally.

## Test plan
- Reset (N=8): assert rst_n=0 mid-drain. Required: in_ready=1, out_valid=0, out_idx=0 and out_last=0 immediately, without waiting for a clock edge. After release, a new vector drains normally.
- Fixed drain (MODE=0, N=8): req=8'b1010_0110, out_ready=1.
  - out_idx sequence is 7, 5, 2, 1 on consecutive cycles.
  - out_last is high only with 1.
  - in_ready is 0 throughout the drain and returns to 1 in the following cycle.
- Backpressure (MODE=0): req=8'b1000_0001, out_ready=0 for 3 cycles. Required: out_idx=7 and out_valid=1 held stable. When out_ready=1, the stream continues 7 then 0.
- Round-robin (MODE=1, N=8):
  - req=8'b1000_0000 grants 7 and sets ptr=6.
  - Next req=8'b1000_0001 grants 0 then 7, with out_last on 7.
  - The same two vectors with MODE=0 give 7, then 7, 0.
- Zero vector and wrap (MODE=1, N=5, W=3):
  - req=0 accepted: out_valid stays 0 and in_ready stays 1.
  - req=5'b10001 grants 4 then 0, leaving ptr=4 (not 7) after granting 0.
  - req=5'b11000 then grants 4 first.

Source files
------------

// File: rtl/prio_serialiser.sv
// Registered priority serialiser: latches an N-bit request vector and emits the index of each
// set bit, one per accepted cycle, in fixed (highest first) or round-robin order.
module prio_serialiser #(
    parameter int unsigned N    = 8,
    parameter int unsigned MODE = 0,
    localparam int unsigned W   = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_idx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last
);

    logic [N-1:0] pending_q, pending_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic [W-1:0] sel;
    logic         found;
    int unsigned  cand;
    logic         busy;
    logic         fire;

    assign busy = (pending_q != '0);
    assign fire = busy && out_ready;

    // Round-robin search walks down from ptr and wraps 0 -> N-1, which for non-power-of-two N
    // must not visit the nonexistent indices between N and 2^W-1.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        cand  = 0;
        if (MODE == 0) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (pending_q[i]) sel = W'(i);
            end
        end else begin
            for (int unsigned off = 0; off < N; off++) begin
                cand = int'(ptr_q) + N - off;
                if (cand >= N) cand = cand - N;
                if (!found && pending_q[cand]) begin
                    sel   = W'(cand);
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        pending_d = pending_q;
        ptr_d     = ptr_q;
        if (!busy) begin
            if (in_valid) pending_d = req;
        end else if (fire) begin
            pending_d[sel] = 1'b0;
            if (MODE != 0) begin
                if (sel == '0) ptr_d = W'(N - 1);
                else           ptr_d = sel - W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            ptr_q     <= W'(N - 1);
        end else begin
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
        end
    end

    assign in_ready  = !busy;
    assign out_valid = busy;
    assign out_idx   = busy ? sel : '0;
    assign out_last  = busy && ((pending_q & (pending_q - N'(1))) == '0);

endmodule

// File: tb/tb_prio_serialiser.sv
// Bench for prio_serialiser: three instances (fixed N=8, round-robin N=8, round-robin N=5)
// share stimulus and are checked every cycle against an index-level reference model.
module tb_prio_serialiser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req_v;
    logic       in_valid;
    logic       out_ready;
    logic       rdy [3];
    logic [2:0] idx [3];
    logic       vld [3];
    logic       lst [3];

    logic [7:0] m_pend [3];
    int         m_ptr  [3];
    int         n_vec  = 0;
    int         n_miss = 0;

    always #5 clk = ~clk;

    prio_serialiser #(.N(8), .MODE(0)) u_fix8 (
        .clk(clk), .rst_n(rst_n), .req(req_v), .in_valid(in_valid), .in_ready(rdy[0]),
        .out_idx(idx[0]), .out_valid(vld[0]), .out_ready(out_ready), .out_last(lst[0])
    );
    prio_serialiser #(.N(8), .MODE(1)) u_rr8 (
        .clk(clk), .rst_n(rst_n), .req(req_v), .in_valid(in_valid), .in_ready(rdy[1]),
        .out_idx(idx[1]), .out_valid(vld[1]), .out_ready(out_ready), .out_last(lst[1])
    );
    prio_serialiser #(.N(5), .MODE(1)) u_rr5 (
        .clk(clk), .rst_n(rst_n), .req(req_v[4:0]), .in_valid(in_valid), .in_ready(rdy[2]),
        .out_idx(idx[2]), .out_valid(vld[2]), .out_ready(out_ready), .out_last(lst[2])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int n_of(input int k);
        return (k == 2) ? 5 : 8;
    endfunction

    function automatic int mode_of(input int k);
        return (k == 0) ? 0 : 1;
    endfunction

    // Index the specification says should be granted next from the model's pending set.
    function automatic int model_sel(input int k);
        int n;
        int i;
        n = n_of(k);
        if (m_pend[k] == 8'h00) return 0;
        if (mode_of(k) == 0) begin
            for (int j = n - 1; j >= 0; j--) if (m_pend[k][j]) return j;
        end else begin
            for (int off = 0; off < n; off++) begin
                i = (m_ptr[k] - off + n) % n;
                if (m_pend[k][i]) return i;
            end
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_pend[k] = 8'h00;
            m_ptr[k]  = n_of(k) - 1;
        end
    endtask

    task automatic model_step();
        int s;
        for (int k = 0; k < 3; k++) begin
            if (m_pend[k] == 8'h00) begin
                if (in_valid) m_pend[k] = req_v & ((k == 2) ? 8'h1F : 8'hFF);
            end else if (out_ready) begin
                s = model_sel(k);
                m_pend[k][s] = 1'b0;
                m_ptr[k] = (s + n_of(k) - 1) % n_of(k);
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("i%0d_in_ready", k), 64'(rdy[k]), 64'(m_pend[k] == 8'h00));
            check($sformatf("i%0d_out_valid", k), 64'(vld[k]), 64'(m_pend[k] != 8'h00));
            check($sformatf("i%0d_out_idx", k), 64'(idx[k]), 64'(model_sel(k)));
            check($sformatf("i%0d_out_last", k), 64'(lst[k]), 64'($countones(m_pend[k]) == 1));
        end
    endtask

    task automatic step(input logic [7:0] r, input logic v, input logic o);
        req_v     = r;
        in_valid  = v;
        out_ready = o;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic drain_all();
        int t;
        t = 0;
        while ((m_pend[0] | m_pend[1] | m_pend[2]) != 8'h00 && t < 100) begin
            step(8'h00, 1'b0, 1'b1);
            t++;
        end
        if (t >= 100) check("drain_timeout", 64'd1, 64'd0);
    endtask

    task automatic load(input logic [7:0] v);
        drain_all();
        step(v, 1'b1, 1'b1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_v     = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #1;
        check_all();
        check("rst_in_ready", 64'(rdy[0]), 64'd1);
        #11;
        rst_n = 1'b1;

        // Fixed-priority drain of 1010_0110.
        load(8'hA6);
        check("fix_idx0", 64'(idx[0]), 64'd7);
        check("fix_rdy0", 64'(rdy[0]), 64'd0);
        step(8'h00, 1'b0, 1'b1);
        check("fix_idx1", 64'(idx[0]), 64'd5);
        check("fix_last1", 64'(lst[0]), 64'd0);
        step(8'h00, 1'b0, 1'b1);
        check("fix_idx2", 64'(idx[0]), 64'd2);
        check("fix_rdy2", 64'(rdy[0]), 64'd0);
        step(8'h00, 1'b0, 1'b1);
        check("fix_idx3", 64'(idx[0]), 64'd1);
        check("fix_last3", 64'(lst[0]), 64'd1);
        step(8'h00, 1'b0, 1'b1);
        check("fix_rdy_after", 64'(rdy[0]), 64'd1);

        // Backpressure holds the grant stable.
        load(8'h81);
        for (int i = 0; i < 3; i++) begin
            step(8'h00, 1'b0, 1'b0);
            check("bp_idx_hold", 64'(idx[0]), 64'd7);
            check("bp_valid_hold", 64'(vld[0]), 64'd1);
        end
        step(8'h00, 1'b0, 1'b1);
        check("bp_idx_next", 64'(idx[0]), 64'd0);
        check("bp_last_next", 64'(lst[0]), 64'd1);

        // Asynchronous reset in the middle of a drain.
        load(8'hA6);
        step(8'h00, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 64'(rdy[0]), 64'd1);
        check("mid_rst_valid", 64'(vld[0]), 64'd0);
        check("mid_rst_idx", 64'(idx[0]), 64'd0);
        check("mid_rst_last", 64'(lst[0]), 64'd0);
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        load(8'h5A);
        drain_all();

        // Round-robin against fixed priority on the same vectors.
        apply_reset();
        load(8'h80);
        check("rr_first", 64'(idx[1]), 64'd7);
        check("rr_first_last", 64'(lst[1]), 64'd1);
        load(8'h81);
        check("rr_second_a", 64'(idx[1]), 64'd0);
        check("fx_second_a", 64'(idx[0]), 64'd7);
        step(8'h00, 1'b0, 1'b1);
        check("rr_second_b", 64'(idx[1]), 64'd7);
        check("rr_second_last", 64'(lst[1]), 64'd1);
        check("fx_second_b", 64'(idx[0]), 64'd0);

        // Zero vector and non-power-of-two wrap on N=5.
        apply_reset();
        load(8'h00);
        check("z_valid", 64'(vld[2]), 64'd0);
        check("z_ready", 64'(rdy[2]), 64'd1);
        load(8'h11);
        check("w_idx0", 64'(idx[2]), 64'd4);
        step(8'h00, 1'b0, 1'b1);
        check("w_idx1", 64'(idx[2]), 64'd0);
        check("w_last1", 64'(lst[2]), 64'd1);
        load(8'h18);
        check("w_after_wrap", 64'(idx[2]), 64'd4);
        drain_all();

        // Randomised traffic with occasional backpressure and one reset.
        for (int i = 0; i < 600; i++) begin
            logic [7:0] r;
            r = 8'($urandom);
            if ($urandom_range(0, 2) == 0) r = r & 8'($urandom);
            step(r, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
            if (i == 300) apply_reset();
        end
        drain_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
